uart_receiver: RTL and testbench

Receives 8N1 asynchronous serial frames on the host-to-board line and presents each byte as a parallel word with a valid strobe and a level-sensitive ready flag. It is the receive-side counterpart of the board's UART transmit path and shares its baud rate and clock. It feeds game logic that consumes host commands. It oversamples the line at 16x baud, synchronises and qualifies the start bit, samples mid-bit and checks the stop bit.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_os_tick.sv | 34 +++
 rtl/uart_receiver.sv | 142 ++++++++++++++
 tb/tb_uart_receiver.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive and transmit paths: frame geometry,
// receiver state encoding and the oversample divider calculation.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Clocks per oversample tick, truncated; zero or less means the rate is unreachable.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: free-running divider that emits a one-clock tick
// every DIV clocks. Shared by the receive and transmit paths.
module uart_os_tick #(
    parameter int DIV = 651
) (
    input  logic clk_in,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 1) begin : g_div_check
        $error("uart_os_tick: DIV must be at least 1 (clock too slow for the baud rate)");
    end

    logic [CW-1:0] cnt_r;

    // Divider counter with a registered tick so downstream logic sees a clean strobe.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            tick  <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
            tick  <= 1'b1;
        end else begin
            cnt_r <= cnt_r + CW'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchroniser, 16x oversampled start qualification,
// mid-bit data sampling, stop-bit check and a ready flag with overrun reporting.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] data_in,
    output logic                 rx_valid,
    output logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int         DIV      = calc_div(CLK_FREQ, BAUD);
    localparam logic [3:0] MID_LAST = 4'd7;
    localparam logic [3:0] BIT_LAST = 4'd15;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_os_check
        $error("uart_receiver: OVERSAMPLE must be 16");
    end

    logic                 tick;
    logic                 rx_meta_r;
    logic                 rx_s;
    rx_state_t            state_r;
    logic [3:0]           tick_cnt_r;
    logic [2:0]           bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;

    uart_os_tick #(
        .DIV (DIV)
    ) u_os_tick (
        .clk_in (clk_in),
        .rst    (rst),
        .tick   (tick)
    );

    // Two-flop synchroniser, reset to the idle (high) line level.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s      <= rx_meta_r;
        end
    end

    // Frame FSM, shift register, output strobes and the ready/overrun flag.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            tick_cnt_r <= 4'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= '0;
            data_in    <= '0;
            rx_valid   <= 1'b0;
            data_ready <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            // A completing good byte below overrides this clear, so an ack in the
            // same cycle leaves the new byte flagged as unread.
            if (rd_ack) begin
                data_ready <= 1'b0;
            end else begin
                data_ready <= data_ready;
            end

            if (tick) begin
                case (state_r)
                    IDLE: begin
                        if (!rx_s) begin
                            state_r    <= START;
                            tick_cnt_r <= 4'd0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    START: begin
                        if (tick_cnt_r == MID_LAST) begin
                            tick_cnt_r <= 4'd0;
                            bit_cnt_r  <= 3'd0;
                            state_r    <= rx_s ? IDLE : DATA;
                        end else begin
                            tick_cnt_r <= tick_cnt_r + 4'd1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt_r == BIT_LAST) begin
                            tick_cnt_r <= 4'd0;
                            shift_r    <= {rx_s, shift_r[DATA_BITS-1:1]};
                            bit_cnt_r  <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == LAST_BIT) begin
                                state_r <= STOP;
                            end else begin
                                state_r <= DATA;
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r + 4'd1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt_r == BIT_LAST) begin
                            tick_cnt_r <= 4'd0;
                            state_r    <= IDLE;
                            if (rx_s) begin
                                data_in    <= shift_r;
                                rx_valid   <= 1'b1;
                                data_ready <= 1'b1;
                                overrun    <= data_ready & ~rd_ack;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r + 4'd1;
                        end
                    end
                    default: begin
                        state_r    <= IDLE;
                        tick_cnt_r <= 4'd0;
                        bit_cnt_r  <= 3'd0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at 16 clocks per bit: a frame-level expectation model
// checked every cycle, plus directed literal checks on the key scenarios.
module tb_uart_receiver;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_ack;
    logic [7:0] data_in;
    logic       rx_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;

    uart_receiver #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .rx         (rx),
        .rd_ack     (rd_ack),
        .data_in    (data_in),
        .rx_valid   (rx_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        int         due;
        logic [7:0] data;
        logic       stop_ok;
    } frame_t;

    frame_t     exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    bit         m_ready = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         ack_at_edge = 1'b0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    int         valid_cyc[$];
    logic [7:0] valid_byte[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    always @(posedge clk_in) ack_at_edge = rd_ack;

    // Frame-level model: each queued frame resolves on its due cycle; otherwise only rd_ack matters.
    always @(negedge clk_in) begin
        bit     e_valid;
        bit     e_ferr;
        bit     e_ovr;
        frame_t f;
        cyc++;
        e_valid = 1'b0;
        e_ferr  = 1'b0;
        e_ovr   = 1'b0;
        if (rst) begin
            exp_q.delete();
            m_ready = 1'b0;
            m_data  = 8'h00;
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            f = exp_q.pop_front();
            if (f.stop_ok) begin
                e_valid = 1'b1;
                e_ovr   = m_ready && !ack_at_edge;
                m_ready = 1'b1;
                m_data  = f.data;
            end else begin
                e_ferr = 1'b1;
                if (ack_at_edge) m_ready = 1'b0;
            end
        end else if (ack_at_edge) begin
            m_ready = 1'b0;
        end
        check("rx_valid", rx_valid, e_valid);
        check("frame_err", frame_err, e_ferr);
        check("overrun", overrun, e_ovr);
        check("data_ready", data_ready, m_ready);
        check("data_in", data_in, m_data);
        if (rx_valid) begin
            n_valid++;
            valid_cyc.push_back(cyc);
            valid_byte.push_back(data_in);
        end
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Result appears 2 sync clocks + 1 detect clock + 152 ticks + 1 register clock after the start edge.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        exp_q.push_back('{due: cyc + 156, data: b, stop_ok: stop});
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (16) @(posedge clk_in);
            #1;
        end
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1;
        idle(1);
        rd_ack = 1'b0;
    endtask

    initial begin
        int start_cyc;
        int idx;
        rst    = 1'b1;
        rx     = 1'b1;
        rd_ack = 1'b0;
        idle(3);
        check("reset data_in", data_in, 8'h00);
        check("reset data_ready", data_ready, 1'b0);
        check("reset rx_valid", rx_valid, 1'b0);
        rst = 1'b0;
        idle(5);

        // good frame
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        idle(4);
        check("a5 data_in", data_in, 8'hA5);
        check("a5 data_ready", data_ready, 1'b1);
        check("a5 latency", valid_cyc[0] - start_cyc, 156);
        check("a5 frame_err count", n_ferr, 0);
        ack_pulse();
        idle(1);
        check("ack clears ready", data_ready, 1'b0);

        // glitch, then a real frame
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(20);
        check("glitch no valid", n_valid, 1);
        send_frame(8'h3C, 1'b1);
        idle(4);
        check("3c data_in", data_in, 8'h3C);
        check("3c valid count", n_valid, 2);

        // framing error
        send_frame(8'h55, 1'b0);
        rx = 1'b1;
        idle(30);
        check("ferr count", n_ferr, 1);
        check("ferr keeps data_in", data_in, 8'h3C);
        check("ferr keeps ready", data_ready, 1'b1);
        check("ferr no valid", n_valid, 2);

        // overrun
        ack_pulse();
        send_frame(8'h11, 1'b1);
        idle(4);
        send_frame(8'h22, 1'b1);
        idle(4);
        check("overrun count", n_ovr, 1);
        check("overrun data_in", data_in, 8'h22);
        check("overrun ready", data_ready, 1'b1);

        // ack coincident with completion of 0x33
        fork
            send_frame(8'h33, 1'b1);
            begin
                repeat (154) @(posedge clk_in);
                #1 rd_ack = 1'b1;
                @(posedge clk_in);
                #1 rd_ack = 1'b0;
            end
        join
        idle(4);
        check("coincide no overrun", n_ovr, 1);
        check("coincide ready", data_ready, 1'b1);
        check("coincide data_in", data_in, 8'h33);

        // reset during data bit 4 of 0xF0
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (85) @(posedge clk_in);
                #1 rst = 1'b1;
                #1;
                check("midreset data_in", data_in, 8'h00);
                check("midreset data_ready", data_ready, 1'b0);
                check("midreset rx_valid", rx_valid, 1'b0);
                repeat (2) @(posedge clk_in);
                #1 rst = 1'b0;
            end
        join
        idle(20);
        check("midreset discards frame", n_valid, 5);
        send_frame(8'h0F, 1'b1);
        idle(4);
        check("0f data_in", data_in, 8'h0F);
        check("0f ready", data_ready, 1'b1);

        // back-to-back frames
        ack_pulse();
        idx = valid_cyc.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        idle(4);
        check("b2b valid count", n_valid, 9);
        if (valid_cyc.size() == idx + 3) begin
            check("b2b gap1", valid_cyc[idx + 1] - valid_cyc[idx], 160);
            check("b2b gap2", valid_cyc[idx + 2] - valid_cyc[idx + 1], 160);
            check("b2b byte0", valid_byte[idx], 8'h00);
            check("b2b byte1", valid_byte[idx + 1], 8'hFF);
            check("b2b byte2", valid_byte[idx + 2], 8'h81);
        end else begin
            check("b2b pulses recorded", valid_cyc.size(), idx + 3);
        end
        check("b2b overrun count", n_ovr, 3);
        check("model drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
